// File: rtl/cache_ram_pkg.sv
// rtl/cache_ram_pkg.sv - shared types and constants for the cache RAM scheduler
//
// Contents:
//   sched_state_t : scheduler FSM state (S_CLEAR zero-fills the array, S_RUN serves requests)
//   req_idx_t     : write requester index (REQ_W0 = refill, REQ_W1 = store-update)
//   CLEAR_VALUE   : word written to every address during a clear
package cache_ram_pkg;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } sched_state_t;

    typedef enum logic {
        REQ_W0 = 1'b0,
        REQ_W1 = 1'b1
    } req_idx_t;

    localparam int unsigned CLEAR_VALUE = 0;

endpackage

// File: rtl/cache_ram_sched_rr_arb2.sv
// rtl/cache_ram_sched_rr_arb2.sv - two-way round-robin arbiter with last-winner pointer
//
// Ports:
//   clk, rst : clock, synchronous active-low reset
//   req[1:0] : request vector (bit 0 = requester 0, bit 1 = requester 1)
//   gnt[1:0] : one-hot (or zero) grant, combinational from req and the pointer
//
// The pointer records the last winner; on a tie the other requester wins.
// Reset points at requester 1 so requester 0 wins the first tie.
module rr_arb2
    import cache_ram_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    req_idx_t last_q, last_d;

    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = (last_q == REQ_W1) ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

    always_comb begin
        last_d = last_q;
        if (gnt[0]) begin
            last_d = REQ_W0;
        end else if (gnt[1]) begin
            last_d = REQ_W1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_q <= REQ_W1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/cache_ram_sched.sv
// rtl/cache_ram_sched.sv - access scheduler in front of one dual-port tag/data BRAM
//
// Ports:
//   clk, rst                        : clock, synchronous active-low reset
//   clear_req / busy                : zero-fill request pulse / clear in progress
//   rd_valid, rd_ready, rd_addr     : lookup request (RAM port A)
//   rd_data_valid, rd_data          : lookup response, one cycle after acceptance
//   w0_* / w1_*                     : refill / store-update write requests (RAM port B)
//   ram_ena, ram_wea, ram_addra, ram_dina, ram_douta : RAM port A
//   ram_enb, ram_web, ram_addrb, ram_dinb            : RAM port B
//
// Build option CACHE_RAM_BYPASS_EN: a read colliding with a granted write to the
// same address is accepted and answered with the write data; without it the read
// is stalled for that cycle and picks up the new data on retry.
module cache_ram_sched
    import cache_ram_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 128,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  clear_req,
    output logic                  busy,

    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [AW-1:0]         rd_addr,
    output logic                  rd_data_valid,
    output logic [DATA_WIDTH-1:0] rd_data,

    input  logic                  w0_valid,
    output logic                  w0_ready,
    input  logic [AW-1:0]         w0_addr,
    input  logic [DATA_WIDTH-1:0] w0_data,

    input  logic                  w1_valid,
    output logic                  w1_ready,
    input  logic [AW-1:0]         w1_addr,
    input  logic [DATA_WIDTH-1:0] w1_data,

    output logic                  ram_ena,
    output logic                  ram_wea,
    output logic [AW-1:0]         ram_addra,
    output logic [DATA_WIDTH-1:0] ram_dina,
    input  logic [DATA_WIDTH-1:0] ram_douta,

    output logic                  ram_enb,
    output logic                  ram_web,
    output logic [AW-1:0]         ram_addrb,
    output logic [DATA_WIDTH-1:0] ram_dinb
);

    sched_state_t          state_q, state_d;
    logic [AW-1:0]         clr_cnt_q, clr_cnt_d;
    logic                  rd_vld_q, rd_vld_d;

    logic                  run;
    logic                  clearing;
    logic [1:0]            arb_req;
    logic [1:0]            gnt;
    logic                  wr_gnt;
    logic [AW-1:0]         wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_fire;

`ifdef CACHE_RAM_BYPASS_EN
    logic                  byp_hit_q, byp_hit_d;
    logic [DATA_WIDTH-1:0] byp_data_q, byp_data_d;
`endif

    // Everything is gated by rst so outputs show reset values while rst is low,
    // not just from the first edge after it falls.
    assign run      = rst && (state_q == S_RUN);
    assign clearing = rst && (state_q == S_CLEAR);
    assign busy     = !rst || (state_q == S_CLEAR);

    assign arb_req = {w1_valid, w0_valid} & {2{run}};

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (arb_req),
        .gnt (gnt)
    );

    assign wr_gnt   = |gnt;
    assign wr_addr  = gnt[1] ? w1_addr : w0_addr;
    assign wr_data  = gnt[1] ? w1_data : w0_data;
    assign w0_ready = gnt[0];
    assign w1_ready = gnt[1];

`ifdef CACHE_RAM_BYPASS_EN
    assign rd_ready = run;
`else
    // Stall the lookup while the winning write targets the same word; the retry
    // then reads the freshly written value from the RAM.
    assign rd_ready = run && !(wr_gnt && (wr_addr == rd_addr));
`endif

    assign rd_fire = rd_valid && rd_ready;

    // Port A: lookups only.
    assign ram_ena   = rd_fire;
    assign ram_wea   = 1'b0;
    assign ram_addra = rd_fire ? rd_addr : '0;
    assign ram_dina  = '0;

    // Port B: clear writes take precedence (writers are never granted while clearing).
    always_comb begin
        ram_enb   = 1'b0;
        ram_web   = 1'b0;
        ram_addrb = '0;
        ram_dinb  = '0;
        if (clearing) begin
            ram_enb   = 1'b1;
            ram_web   = 1'b1;
            ram_addrb = clr_cnt_q;
            ram_dinb  = DATA_WIDTH'(CLEAR_VALUE);
        end else if (wr_gnt) begin
            ram_enb   = 1'b1;
            ram_web   = 1'b1;
            ram_addrb = wr_addr;
            ram_dinb  = wr_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        rd_vld_d  = rd_fire;
        case (state_q)
            S_CLEAR: begin
                // clear_req is ignored here so a running clear is never restarted.
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == AW'(DEPTH - 1)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (clear_req) begin
                    state_d   = S_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            default: begin
                state_d   = S_CLEAR;
                clr_cnt_d = '0;
            end
        endcase
    end

`ifdef CACHE_RAM_BYPASS_EN
    always_comb begin
        byp_hit_d  = rd_fire && wr_gnt && (wr_addr == rd_addr);
        byp_data_d = byp_hit_d ? wr_data : '0;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_CLEAR;
            clr_cnt_q  <= '0;
            rd_vld_q   <= 1'b0;
`ifdef CACHE_RAM_BYPASS_EN
            byp_hit_q  <= 1'b0;
            byp_data_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            rd_vld_q   <= rd_vld_d;
`ifdef CACHE_RAM_BYPASS_EN
            byp_hit_q  <= byp_hit_d;
            byp_data_q <= byp_data_d;
`endif
        end
    end

    assign rd_data_valid = rst && rd_vld_q;

`ifdef CACHE_RAM_BYPASS_EN
    assign rd_data = !rd_data_valid ? '0 : (byp_hit_q ? byp_data_q : ram_douta);
`else
    assign rd_data = rd_data_valid ? ram_douta : '0;
`endif

endmodule

// File: tb/tb_cache_ram_sched.sv
// tb/tb_cache_ram_sched.sv - scoreboard bench for cache_ram_sched (DEPTH=8)
module tb_cache_ram_sched;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear_req;
    logic          busy;
    logic          rd_valid, rd_ready, rd_data_valid;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          w0_valid, w0_ready, w1_valid, w1_ready;
    logic [AW-1:0] w0_addr, w1_addr;
    logic [DW-1:0] w0_data, w1_data;
    logic          ram_ena, ram_wea, ram_enb, ram_web;
    logic [AW-1:0] ram_addra, ram_addrb;
    logic [DW-1:0] ram_dina, ram_dinb;
    logic [DW-1:0] ram_douta;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] exp_q [$];
    int            total = 0;
    int            bad   = 0;

    always #5 clk = ~clk;

    cache_ram_sched #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_data_valid(rd_data_valid), .rd_data(rd_data),
        .w0_valid(w0_valid), .w0_ready(w0_ready), .w0_addr(w0_addr), .w0_data(w0_data),
        .w1_valid(w1_valid), .w1_ready(w1_ready), .w1_addr(w1_addr), .w1_data(w1_data),
        .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
        .ram_douta(ram_douta),
        .ram_enb(ram_enb), .ram_web(ram_web), .ram_addrb(ram_addrb), .ram_dinb(ram_dinb)
    );

    // Behavioural dual-port BRAM, 1-cycle read latency, read-first.
    initial for (int i = 0; i < DEPTH; i++) mem[i] = 32'hDEAD0000 + i;
    always @(posedge clk) begin
        if (ram_enb && ram_web) mem[ram_addrb] <= ram_dinb;
        if (ram_ena) ram_douta <= mem[ram_addra];
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every response is matched against the oldest expected value.
    always @(negedge clk) begin
        if (rd_data_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_unexpected actual=%h required=no_response at %0t", rd_data, $time);
            end else begin
                chk("rd_data", rd_data, exp_q.pop_front());
            end
        end
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic exp_rdy, input logic [DW-1:0] exp_d);
        rd_valid = 1'b1;
        rd_addr  = a;
        #2;
        chk("busy_run", busy, 0);
        chk("rd_ready", rd_ready, exp_rdy);
        if (rd_ready) exp_q.push_back(exp_d);
        next_cyc();
        rd_valid = 1'b0;
    endtask

    task automatic wr0(input logic [AW-1:0] a, input logic [DW-1:0] d);
        w0_valid = 1'b1;
        w0_addr  = a;
        w0_data  = d;
        #2;
        chk("w0_ready", w0_ready, 1);
        next_cyc();
        w0_valid = 1'b0;
    endtask

    task automatic clear_cycles(input string name);
        for (int c = 0; c < DEPTH; c++) begin
            #2;
            chk({name, "_busy"}, busy, 1);
            chk({name, "_enb"}, ram_enb & ram_web, 1);
            chk({name, "_addrb"}, ram_addrb, c);
            chk({name, "_dinb"}, ram_dinb, 0);
            next_cyc();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; clear_req = 1'b0;
        rd_valid = 1'b0; rd_addr = '0;
        w0_valid = 1'b0; w0_addr = '0; w0_data = '0;
        w1_valid = 1'b0; w1_addr = '0; w1_data = '0;
        repeat (3) next_cyc();
        #2;
        chk("rst_busy", busy, 1);
        chk("rst_rd_ready", rd_ready, 0);
        chk("rst_ram_ena", ram_ena, 0);
        chk("rst_ram_enb", ram_enb, 0);
        chk("rst_rd_valid", rd_data_valid, 0);
        chk("rst_rd_data", rd_data, 0);

        // Reset release: 8 zero-fill cycles, then ready in cycle 8.
        next_cyc();
        rst = 1'b1;
        clear_cycles("init_clr");
        #2;
        chk("c8_busy", busy, 0);
        chk("c8_rd_ready", rd_ready, 1);
        next_cyc();
        rd(3'd5, 1'b1, 32'h0);

        // Contention: w0 wins the first tie, then strict alternation.
        w0_valid = 1'b1; w0_addr = 3'd1; w0_data = 32'hA;
        w1_valid = 1'b1; w1_addr = 3'd2; w1_data = 32'hB;
        for (int k = 0; k < 4; k++) begin
            #2;
            chk("rr_w0_ready", w0_ready, (k % 2) == 0);
            chk("rr_w1_ready", w1_ready, (k % 2) == 1);
            chk("rr_addrb", ram_addrb, (k % 2) == 0 ? 1 : 2);
            chk("rr_dinb", ram_dinb, (k % 2) == 0 ? 32'hA : 32'hB);
            next_cyc();
        end
        w0_valid = 1'b0;
        #2;
        chk("single_w1_ready", w1_ready, 1);
        chk("single_w1_addrb", ram_addrb, 2);
        next_cyc();
        w1_valid = 1'b0;

        // Same-cycle collision on address 3.
        w0_valid = 1'b1; w0_addr = 3'd3; w0_data = 32'h1234;
        rd_valid = 1'b1; rd_addr = 3'd3;
        #2;
        chk("col_w0_ready", w0_ready, 1);
`ifdef CACHE_RAM_BYPASS_EN
        chk("col_rd_ready", rd_ready, 1);
        if (rd_ready) exp_q.push_back(32'h1234);
        next_cyc();
        w0_valid = 1'b0; rd_valid = 1'b0;
`else
        chk("col_rd_ready", rd_ready, 0);
        if (rd_ready) exp_q.push_back(32'h1234);
        next_cyc();
        w0_valid = 1'b0;
        rd(3'd3, 1'b1, 32'h1234);
`endif

        // Flush: fill with 0xFF, read addr 4 in the clear_req cycle.
        for (int a = 0; a < DEPTH; a++) wr0(a[AW-1:0], 32'hFF);
        clear_req = 1'b1;
        rd(3'd4, 1'b1, 32'hFF);
        rd_valid = 1'b1; rd_addr = 3'd2;
        w0_valid = 1'b1; w0_addr = 3'd0; w0_data = 32'h99;
        for (int c = 0; c < DEPTH; c++) begin
            clear_req = (c == 3);
            #2;
            chk("fl_busy", busy, 1);
            chk("fl_rd_ready", rd_ready, 0);
            chk("fl_w0_ready", w0_ready, 0);
            chk("fl_addrb", ram_addrb, c);
            next_cyc();
        end
        clear_req = 1'b0; rd_valid = 1'b0; w0_valid = 1'b0;
        for (int a = 0; a < DEPTH; a++) rd(a[AW-1:0], 1'b1, 32'h0);

        // Reset mid-clear at clr_cnt=5: clear restarts from address 0.
        wr0(3'd6, 32'h77);
        clear_req = 1'b1;
        next_cyc();
        clear_req = 1'b0;
        for (int c = 0; c < 5; c++) next_cyc();
        #2;
        chk("mid_pre_addrb", ram_addrb, 5);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 1);
        chk("mid_rst_enb", ram_enb, 0);
        next_cyc();
        rst = 1'b1;
        clear_cycles("re_clr");
        rd(3'd6, 1'b1, 32'h0);

        // A read in flight when reset hits produces no response.
        rd_valid = 1'b1; rd_addr = 3'd0;
        #2;
        chk("drop_rd_ready", rd_ready, 1);
        next_cyc();
        rd_valid = 1'b0;
        rst = 1'b0;
        #2;
        chk("drop_rd_valid", rd_data_valid, 0);
        next_cyc();
        rst = 1'b1;
        repeat (DEPTH) next_cyc();

        // Write in T, read same address in T+1.
        wr0(3'd6, 32'h55);
        rd(3'd6, 1'b1, 32'h55);

        repeat (3) next_cyc();
        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_ram_sched.md
# cache_ram_sched

Scheduler in front of one `dual_port_bram` instance (tag/data array of the L1 caches). Port A is dedicated to lookups; port B is shared by two write requesters (refill, store-update) under round-robin arbitration. The block also zero-fills the whole array after reset or on a flush request, and handles same-cycle read/write collisions on one address.

## Interface
- `DATA_WIDTH`, 32, word width; must match the attached RAM.
- `DEPTH`, 128, number of words; power of two ≥ 2; `AW = $clog2(DEPTH)`.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-low reset.
- `clear_req` in 1: single-cycle pulse; zero-fill the whole array.
- `busy` out 1: clear in progress.
- `rd_valid` in 1 / `rd_ready` out 1 / `rd_addr` in AW: lookup request.
- `rd_data_valid` out 1 / `rd_data` out DATA_WIDTH: lookup response.
- `w0_valid` in 1 / `w0_ready` out 1 / `w0_addr` in AW / `w0_data` in DATA_WIDTH: refill write.
- `w1_valid` in 1 / `w1_ready` out 1 / `w1_addr` in AW / `w1_data` in DATA_WIDTH: store-update write.
- `ram_ena`, `ram_wea` out 1 / `ram_addra` out AW / `ram_dina` out DATA_WIDTH: RAM port A.
- `ram_enb`, `ram_web` out 1 / `ram_addrb` out AW / `ram_dinb` out DATA_WIDTH: RAM port B.
- `ram_douta` in DATA_WIDTH: RAM port A read data; read latency 1 cycle.

## Operation
- FSM states: S_CLEAR, S_RUN.
  - S_CLEAR: port B writes zero at `clr_cnt`, then increments `clr_cnt`.
  - S_CLEAR → S_RUN after the write of `DEPTH-1`.
  - S_RUN → S_CLEAR on `clear_req`, with `clr_cnt` reset to 0.
- `clear_req` during S_CLEAR is ignored; the count is not restarted.
- `busy` = (state == S_CLEAR).
- In S_CLEAR, `rd_ready`, `w0_ready` and `w1_ready` are all 0.
- In S_RUN, in the same cycle `clear_req` is asserted, requests are still accepted. The clear starts the next cycle.
- Read path:
  - Accepted when `rd_valid & rd_ready`.
  - Drives `ram_ena=1`, `ram_wea=0`, `ram_addra=rd_addr`.
  - Port A never writes; `ram_dina` = 0.
- Write arbitration:
  - Round-robin between w0 and w1, using a `last` pointer that records the last winner.
  - When both are valid, the requester not equal to `last` wins.
  - With one valid, that one wins.
  - `last` updates only on grant.
  - `wN_ready` = S_RUN & grant_N.
  - The grant drives `ram_enb=ram_web=1` and the winner's addr/data on port B.
- Collision: a read accepted in the same cycle as a granted write to the same address is forwarded (see Configuration).
- A response is produced for every accepted read, including reads accepted in the cycle a clear begins.

## Timing
- Reset values (held while `rst`=0):
  - state=S_CLEAR, `clr_cnt`=0, `last`=w1 (so w0 wins the first tie).
  - `busy`=1; all readies 0; `rd_data_valid`=0; `rd_data`=0.
  - All `ram_*` enables 0.
- Cycle 0 is the first cycle with `rst`=1.
  - Cycle 0 writes address 0.
  - Cycle `DEPTH-1` writes address `DEPTH-1`.
  - S_RUN and readies are first available in cycle `DEPTH`.
- Read latency: accept in cycle T → `rd_data_valid`=1 with data in T+1. Otherwise `rd_data_valid`=0.
- Readies are combinational from state, `*_valid` and addresses. No combinational path from `ram_douta` to any ready.
- Write in T, read of the same address in T+1: the read returns the new data (RAM write completes at the T edge).
- Reset asserted mid-clear or mid-run: everything returns to reset values. The clear restarts from address 0; in-flight read responses are dropped.

## Configuration
- `CACHE_RAM_BYPASS_EN` defined:
  - Same-cycle same-address read+write: the read is accepted.
  - Write data is registered and returned in T+1 instead of `ram_douta`.
- Not defined:
  - `rd_ready`=0 in any cycle where the granted write's address equals `rd_addr`.
  - The read is accepted in a later cycle and returns the new data.
  - `rd_data` always equals `ram_douta`.

## Structure
- `cache_ram_pkg`:
  - state enum `sched_state_t` {S_CLEAR, S_RUN};
  - requester index type;
  - `CLEAR_VALUE` = 0.
- Sub-module `rr_arb2`: 2-way round-robin arbiter with `req[1:0]`, `gnt[1:0]`, `last` pointer, clocked by `clk`/`rst`.
- Top level contains the FSM, clear counter, read/bypass pipeline register and port muxing.

## Test plan
All scenarios use DEPTH=8, DATA_WIDTH=32.
- Reset release:
  - `busy`=1 for cycles 0–7;
  - port B writes 0 to addresses 0..7 in order;
  - readies rise in cycle 8;
  - reading address 5 returns 0.
- Contention:
  - w0 and w1 continuously valid (addr 1/2, data 0xA/0xB) → grants alternate w0, w1, w0, w1;
  - single w1 valid → immediate grant.
- Collision:
  - w0 writes 0x1234 to addr 3 while a read of addr 3 is requested;
  - with the macro: read accepted, `rd_data`=0x1234 next cycle;
  - without: `rd_ready`=0 that cycle, then 0x1234 on the retry.
- Flush:
  - fill addrs 0..7 with 0xFF;
  - `clear_req` in the same cycle as an accepted read of addr 4 → that read returns 0xFF;
  - `busy` for 8 cycles; all reads afterwards return 0.
- Reset mid-clear:
  - deassert `rst` at `clr_cnt`=5 for 1 cycle → clear restarts at address 0 and takes the full 8 cycles.
- Back-to-back:
  - write 0x55 to addr 6 in T, read addr 6 in T+1 → `rd_data`=0x55 in T+2.
